barrel_rotator_left_seq: RTL and testbench

//   Multi-cycle left barrel rotator; the inverse of barrel_shifter_stage (rotate-right).

---
 rtl/w10_shift_pkg.sv | 20 ++
 rtl/rotl_stage.sv | 16 +
 rtl/barrel_rotator_left_seq.sv | 91 +++++++++
 tb/tb_barrel_rotator_left_seq.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/w10_shift_pkg.sv
// Shared definitions for the W10 rotate datapath: default width, FSM encoding, rotate helper.
package w10_shift_pkg;

  localparam int unsigned DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Rotate a DEF_WIDTH word left by k (modulo the width).
  function automatic logic [DEF_WIDTH-1:0] rotl(input logic [DEF_WIDTH-1:0] data,
                                                input int unsigned k);
    logic [2*DEF_WIDTH-1:0] dd;
    dd = {data, data} << (k % DEF_WIDTH);
    return dd[2*DEF_WIDTH-1:DEF_WIDTH];
  endfunction

endpackage

// File: rtl/rotl_stage.sv
// One barrel stage: conditionally rotate left by a constant distance.
module rotl_stage #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIST  = 1
) (
  input  logic [WIDTH-1:0] d,
  input  logic             en,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] rot;

  assign rot = {d[WIDTH-1-DIST:0], d[WIDTH-1:WIDTH-DIST]};
  assign q   = en ? rot : d;

endmodule

// File: rtl/barrel_rotator_left_seq.sv
// Multi-cycle left rotator: one log2 stage per clock between valid/ready handshakes.
module barrel_rotator_left_seq
  import w10_shift_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [AMT_W-1:0] amt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y
);

  localparam int unsigned STAGE_W = (AMT_W > 1) ? $clog2(AMT_W) : 1;
  localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(AMT_W - 1);

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     data_q;
  logic [AMT_W-1:0]     amt_q;
  logic [STAGE_W-1:0]   stage_q;
  logic [WIDTH-1:0]     stage_y [AMT_W];

  // Stage i rotates by 2**i when bit i of the captured amount is set.
  for (genvar i = 0; i < AMT_W; i++) begin : g_stage
    rotl_stage #(
      .WIDTH (WIDTH),
      .DIST  (1 << i)
    ) u_stage (
      .d  (data_q),
      .en (amt_q[i]),
      .q  (stage_y[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = SHIFT;
      SHIFT:   if (stage_q == LAST_STAGE) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE:    in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath: capture on accept, then walk the stages one per clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      amt_q   <= '0;
      stage_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            data_q  <= a;
            amt_q   <= amt;
            stage_q <= '0;
          end
        end
        SHIFT: begin
          data_q <= stage_y[stage_q];
          if (stage_q != LAST_STAGE) stage_q <= stage_q + STAGE_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign y = data_q;

endmodule

// File: tb/tb_barrel_rotator_left_seq.sv
// Self-checking bench for barrel_rotator_left_seq against an arithmetic rotate model.
module tb_barrel_rotator_left_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [2:0] amt;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] y;

  int checks   = 0;
  int failures = 0;

  barrel_rotator_left_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .amt       (amt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_rotl(input logic [7:0] v, input int k);
    int unsigned w;
    w = (int'(v) << k) | (int'(v) >> (8 - k));
    return 8'(w);
  endfunction

  function automatic logic [7:0] model_rotr(input logic [7:0] v, input int k);
    int unsigned w;
    w = (int'(v) >> k) | (int'(v) << (8 - k));
    return 8'(w);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One transaction: accept, measure latency, hold off for 'hold' cycles, then handshake.
  task automatic run_op(input string tag, input logic [7:0] av, input logic [2:0] k,
                        input logic [7:0] exp, input int hold, input bit poke);
    int cyc;
    check({tag, " in_ready idle"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    a        = av;
    amt      = k;
    tick();
    in_valid = 1'b0;
    a        = 8'hxx;
    cyc      = 0;
    while (!out_valid && cyc < 20) begin
      if (poke && cyc == 1) begin
        in_valid = 1'b1;
        a        = 8'hFF;
        amt      = 3'd7;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    check({tag, " latency"}, 32'(cyc), 32'd3);
    check({tag, " y"}, 32'(y), 32'(exp));
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, " hold out_valid"}, 32'(out_valid), 32'd1);
      check({tag, " hold y"}, 32'(y), 32'(exp));
      check({tag, " hold in_ready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a         = 8'h5A;
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check({tag, " post out_valid"}, 32'(out_valid), 32'd0);
    check({tag, " post in_ready"}, 32'(in_ready), 32'd1);
    // The in_valid offered during the handshake must not have started a new word.
    tick();
    check({tag, " no capture"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [7:0] ra;
    logic [2:0] rk;
    logic [7:0] sweep_exp [8];
    sweep_exp[0] = 8'hAB; sweep_exp[1] = 8'h57; sweep_exp[2] = 8'hAE; sweep_exp[3] = 8'h5D;
    sweep_exp[4] = 8'hBA; sweep_exp[5] = 8'h75; sweep_exp[6] = 8'hEA; sweep_exp[7] = 8'hD5;

    rst = 1'b1; in_valid = 1'b0; a = '0; amt = '0; out_ready = 1'b0;
    tick();
    tick();
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset y", 32'(y), 32'h00);
    rst = 1'b0;
    tick();

    for (int k = 0; k < 8; k++) begin
      check("sweep model", 32'(model_rotl(8'hAB, k)), 32'(sweep_exp[k]));
      run_op("sweep", 8'hAB, 3'(k), sweep_exp[k], 0, 1'b0);
    end

    for (int k = 0; k < 8; k++)
      run_op("inverse", model_rotr(8'hAB, k), 3'(k), 8'hAB, 0, 1'b0);

    run_op("backpressure", 8'h81, 3'd1, 8'h03, 5, 1'b0);
    run_op("ignored input", 8'h3C, 3'd2, 8'hF0, 1, 1'b1);

    // Reset during the second SHIFT cycle discards the word.
    in_valid = 1'b1; a = 8'h0F; amt = 3'd4;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midreset in_ready", 32'(in_ready), 32'd1);
    check("midreset out_valid", 32'(out_valid), 32'd0);
    check("midreset y", 32'(y), 32'h00);
    tick();
    check("midreset stays idle", 32'(out_valid), 32'd0);
    run_op("after reset", 8'h0F, 3'd4, 8'hF0, 0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      ra = 8'($urandom);
      rk = 3'($urandom_range(0, 7));
      run_op("random", ra, rk, model_rotl(ra, int'(rk)), int'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
